// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and helpers for the round-robin register-bank arbiter.
// Holds the FSM state encoding, default widths and the one-hot grant helper.
package reg_bank_arb_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_DW       = 16;
  localparam int DEF_AW       = 4;
  localparam int DEF_HOLD_MAX = 15;
  localparam int MAX_NREQ     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bus of the register-bank arbiter: packed per-requester
// request fields in, grant/ack/read data and status out.
interface reg_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 4
);
  logic [NREQ-1:0]    i_req;
  logic [NREQ-1:0]    i_we;
  logic [NREQ*AW-1:0] i_addr;
  logic [NREQ*DW-1:0] i_wdata;
  logic [NREQ-1:0]    o_gnt;
  logic [NREQ-1:0]    o_ack;
  logic [DW-1:0]      o_rdata;
  logic               o_busy;
  logic               o_timeout;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output o_gnt, o_ack, o_rdata, o_busy, o_timeout
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  o_gnt, o_ack, o_rdata, o_busy, o_timeout
  );
endinterface

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after rr_ptr,
// wrapping modulo NREQ, so the previous winner is considered last.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [IW-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(rr_ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter/sequencer owning a 2**AW x DW register bank shared by NREQ requesters.
// Optional RELEASE hold timeout is enabled by defining REG_BANK_ARB_TIMEOUT_EN.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input logic               clk,
  input logic               rst,
  reg_bank_arbiter_if.slave bus
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 2 ** AW;

  state_t          state_q, state_d;
  logic [IW-1:0]   winner_q, winner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   bank_q [DEPTH];
  logic [DW-1:0]   bank_d [DEPTH];

  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            cur_req;
  logic            cur_we;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata;
  logic            force_rel;

  // Request fields of the current winner; requesters hold them until ack.
  assign cur_req   = bus.i_req[winner_q];
  assign cur_we    = bus.i_we[winner_q];
  assign cur_addr  = bus.i_addr[int'(winner_q)*AW +: AW];
  assign cur_wdata = bus.i_wdata[int'(winner_q)*DW +: DW];

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req    (bus.i_req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    bank_d   = bank_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          winner_d = pick_idx;
          gnt_d    = NREQ'(onehot(3'(pick_idx)));
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // A requester that withdraws before access gets neither ack nor a bank update.
        if (!cur_req) begin
          gnt_d    = '0;
          rr_ptr_d = winner_q;
          state_d  = IDLE;
        end else begin
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cur_we) bank_d[cur_addr] = cur_wdata;
        else        rdata_d          = bank_q[cur_addr];
        ack_d   = NREQ'(onehot(3'(winner_q)));
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!cur_req || force_rel) begin
          gnt_d    = '0;
          rr_ptr_d = winner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= '0;
      rr_ptr_q <= IW'(NREQ - 1);
      gnt_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      bank_q   <= bank_d;
    end
  end

`ifdef REG_BANK_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;

  // Counter is zero on the first RELEASE cycle, so the HOLD_MAX-th cycle forces release.
  always_comb begin
    hold_cnt_d = (state_q == RELEASE) ? hold_cnt_q + CW'(1) : '0;
    force_rel  = (state_q == RELEASE) && cur_req && (hold_cnt_q == CW'(HOLD_MAX - 1));
    timeout_d  = force_rel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  logic unused_hold;

  assign force_rel     = 1'b0;
  assign unused_hold   = (HOLD_MAX != 0);
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_gnt   = gnt_q;
  assign bus.o_ack   = ack_q;
  assign bus.o_rdata = rdata_q;
  assign bus.o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed scoreboard bench for reg_bank_arbiter: expected acks are queued when
// a request is driven and compared when the DUT pulses o_ack.
module tb_reg_bank_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter_if #(.NREQ(4), .DW(16), .AW(4)) bus ();

  reg_bank_arbiter #(
    .NREQ     (4),
    .DW       (16),
    .AW       (4),
    .HOLD_MAX (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          k;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int k, input bit rd, input logic [15:0] d);
    exp_t e;
    e.k    = k;
    e.rd   = rd;
    e.data = d;
    sb.push_back(e);
  endfunction

  // Scoreboard: every ack pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.o_ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 32'(bus.o_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_onehot", 32'(bus.o_ack), 32'd1 << e.k);
        if (e.rd) check("rdata", 32'(bus.o_rdata), 32'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit we, input logic [3:0] a, input logic [15:0] d);
    bus.i_we[k]            = we;
    bus.i_addr[k*4 +: 4]   = a;
    bus.i_wdata[k*16 +: 16] = d;
    bus.i_req[k]           = 1'b1;
  endtask

  task automatic wait_gnt(output int g);
    g = -1;
    for (int n = 0; n < 12 && g < 0; n++) begin
      step();
      for (int b = 0; b < 4; b++) if (bus.o_gnt[b] === 1'b1) g = b;
    end
  endtask

  task automatic wait_ack(input int k);
    bit seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      step();
      seen = (bus.o_ack[k] === 1'b1);
    end
    check("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int n = 0; n < 20 && !idle; n++) begin
      step();
      idle = (bus.o_busy === 1'b0);
    end
    check("return_idle", 32'(idle), 32'd1);
  endtask

  task automatic run_access(input int k, input bit we, input logic [3:0] a,
                            input logic [15:0] d, input logic [15:0] exp_rd);
    int cyc  = 0;
    bit seen = 1'b0;
    push(k, !we, exp_rd);
    drive(k, we, a, d);
    while (!seen && cyc < 12) begin
      step();
      cyc++;
      seen = (bus.o_ack[k] === 1'b1);
    end
    check("ack_latency", 32'(cyc), 32'd3);
    step();
    bus.i_req[k] = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.i_req = '0;
    step();
    step();
    check("rst_gnt",     32'(bus.o_gnt),     32'd0);
    check("rst_ack",     32'(bus.o_ack),     32'd0);
    check("rst_rdata",   32'(bus.o_rdata),   32'd0);
    check("rst_busy",    32'(bus.o_busy),    32'd0);
    check("rst_timeout", 32'(bus.o_timeout), 32'd0);
    rst = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    rst         = 1'b1;
    bus.i_req   = '0;
    bus.i_we    = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;

    // Reset state, then write and read back through requester 0
    do_reset();
    run_access(0, 1'b1, 4'd3, 16'hA5A5, 16'h0000);
    run_access(0, 1'b0, 4'd3, 16'h0000, 16'hA5A5);

    // All four requesting: strict rotation 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.i_we[k]             = 1'b1;
      bus.i_addr[k*4 +: 4]    = 4'(8 + k);
      bus.i_wdata[k*16 +: 16] = 16'hB000 + 16'(k);
    end
    bus.i_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(g);
      check("rr_order", 32'(g), 32'(order[n]));
      push(order[n], 1'b0, 16'h0000);
      wait_ack(order[n]);
      step();
      bus.i_req[order[n]] = 1'b0;
      if (n < 4) begin
        step();
        bus.i_req[order[n]] = 1'b1;
      end
    end
    bus.i_req = '0;
    wait_idle();
    for (int k = 0; k < 4; k++)
      run_access(3, 1'b0, 4'(8 + k), 16'h0000, 16'hB000 + 16'(k));

    // Requester 2 withdraws during GRANT; pointer must move to 2
    drive(2, 1'b1, 4'd7, 16'hDEAD);
    wait_gnt(g);
    check("abort_gnt", 32'(g), 32'd2);
    bus.i_req[2] = 1'b0;
    step();
    check("abort_gnt_clear", 32'(bus.o_gnt), 32'd0);
    check("abort_busy",      32'(bus.o_busy), 32'd0);
    push(3, 1'b1, 16'h0000);
    push(0, 1'b1, 16'h0000);
    drive(3, 1'b0, 4'd7, 16'h0000);
    drive(0, 1'b0, 4'd7, 16'h0000);
    wait_gnt(g);
    check("after_abort_gnt", 32'(g), 32'd3);
    wait_ack(3);
    step();
    bus.i_req[3] = 1'b0;
    wait_gnt(g);
    check("after_abort_gnt2", 32'(g), 32'd0);
    wait_ack(0);
    step();
    bus.i_req[0] = 1'b0;
    wait_idle();

    // Reset during ACCESS of a write clears the bank and drops the transfer
    run_access(1, 1'b1, 4'd5, 16'h5555, 16'h0000);
    drive(1, 1'b1, 4'd5, 16'h1234);
    wait_gnt(g);
    check("midrst_gnt", 32'(g), 32'd1);
    step();
    check("midrst_busy", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_gnt0",  32'(bus.o_gnt),   32'd0);
    check("midrst_ack0",  32'(bus.o_ack),   32'd0);
    check("midrst_busy0", 32'(bus.o_busy),  32'd0);
    check("midrst_rdata", 32'(bus.o_rdata), 32'd0);
    bus.i_req = '0;
    step();
    rst = 1'b0;
    step();
    run_access(1, 1'b0, 4'd5, 16'h0000, 16'h0000);

    // Requester 1 holds req for 20 cycles after its ack while 2 waits
    push(1, 1'b0, 16'h0000);
    push(2, 1'b1, 16'h0C0C);
    drive(1, 1'b1, 4'd2, 16'h0C0C);
    wait_gnt(g);
    check("hold_gnt", 32'(g), 32'd1);
    drive(2, 1'b0, 4'd2, 16'h0000);
    wait_ack(1);
    for (int j = 1; j <= 20; j++) begin
      step();
`ifdef REG_BANK_ARB_TIMEOUT_EN
      if (j < 15) begin
        check("hold_gnt1", 32'(bus.o_gnt),     32'h2);
        check("hold_to0",  32'(bus.o_timeout), 32'd0);
      end else if (j == 15) begin
        check("to_pulse",  32'(bus.o_timeout), 32'd1);
        check("to_gnt0",   32'(bus.o_gnt),     32'd0);
      end else if (j == 16) begin
        check("to_next_gnt", 32'(bus.o_gnt),     32'h4);
        check("to_end",      32'(bus.o_timeout), 32'd0);
      end else if (j == 19) begin
        bus.i_req = '0;
      end
`else
      check("hold_gnt1", 32'(bus.o_gnt),     32'h2);
      check("hold_to0",  32'(bus.o_timeout), 32'd0);
`endif
    end
`ifndef REG_BANK_ARB_TIMEOUT_EN
    bus.i_req[1] = 1'b0;
    wait_gnt(g);
    check("hold_next_gnt", 32'(g), 32'd2);
    wait_ack(2);
    step();
    bus.i_req[2] = 1'b0;
`endif
    wait_idle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
